// File: rtl/alu_pkg.sv
// Shared types for the accumulator ALU: opcodes and flag bundle.
// Imported by alu_core and alu_accum.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_SAR  = 4'd8,
    ALU_ROL  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_PASS = 4'd11,
    ALU_INC  = 4'd12,
    ALU_DEC  = 4'd13,
    ALU_MUL  = 4'd14,
    ALU_CMP  = 4'd15
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  localparam op_e OP_MUL = ALU_MUL;
  localparam op_e OP_CMP = ALU_CMP;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU datapath: r = a op b, plus {N,Z,V,C}.
// Ports: a, b (W), op (op_e) in; r (W), f (flags_t) out. MUL is not done here.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] r,
  output flags_t       f
);

  localparam int SHW = $clog2(W);
  localparam logic [SHW:0] WL = (SHW+1)'(W);

  logic [SHW-1:0] sh;
  logic [W:0]     sum;
  logic [W:0]     dif;
  logic [W:0]     inc;
  logic [W:0]     dec;
  logic [W:0]     shl;
  logic [W:0]     shr;
  logic signed [W:0] sar;
  logic [SHW:0]   rsh;
  logic           c;
  logic           v;

  assign sh  = b[SHW-1:0];
  assign rsh = WL - {1'b0, sh};
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign inc = {1'b0, a} + (W+1)'(1);
  assign dec = {1'b0, a} - (W+1)'(1);
  // Extra bit catches the last bit shifted out; shift of 0 leaves it 0.
  assign shl = {1'b0, a} << sh;
  assign shr = {a, 1'b0} >> sh;
  assign sar = $signed({a, 1'b0}) >>> sh;

  always_comb begin
    r = a;
    c = 1'b0;
    v = 1'b0;
    unique case (op)
      ALU_ADD: begin
        r = sum[W-1:0];
        c = sum[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SUB, ALU_CMP: begin
        r = dif[W-1:0];
        c = dif[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOT:  r = ~a;
      ALU_SHL: begin
        r = shl[W-1:0];
        c = shl[W];
      end
      ALU_SHR: begin
        r = shr[W:1];
        c = shr[0];
      end
      ALU_SAR: begin
        r = sar[W:1];
        c = sar[0];
      end
      ALU_ROL: begin
        r = (a << sh) | (a >> rsh);
        c = r[W-1];
      end
      ALU_ROR: begin
        r = (a >> sh) | (a << rsh);
        c = r[0];
      end
      ALU_PASS: r = b;
      ALU_INC: begin
        r = inc[W-1:0];
        c = inc[W];
        v = !a[W-1] && r[W-1];
      end
      ALU_DEC: begin
        r = dec[W-1:0];
        c = dec[W];
        v = a[W-1] && !r[W-1];
      end
      ALU_MUL: r = a;
      default: r = a;
    endcase
  end

  assign f.n = r[W-1];
  assign f.z = (r == '0);
  assign f.v = v;
  assign f.c = c;

endmodule

// File: rtl/alu_accum.sv
// Accumulator ALU: acc/flags registers, IDLE/MUL FSM, shift-add multiplier.
// Ports: CLK100MHZ, rst, load, start, op, b in; acc, flags, busy, done, err out.
// Macro ALU_MUL_EN enables the iterative MUL; without it opcode 14 raises err.
module alu_accum
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         CLK100MHZ,
  input  logic         rst,
  input  logic         load,
  input  logic         start,
  input  op_e          op,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc,
  output flags_t       flags,
  output logic         busy,
  output logic         done,
  output logic         err
);

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;
`else
  typedef enum logic {S_IDLE} state_e;
`endif

  state_e       state;
  state_e       state_n;
  logic [W-1:0] acc_n;
  flags_t       flags_n;
  logic         done_n;
  logic         err_n;
  logic [W-1:0] core_r;
  flags_t       core_f;

`ifdef ALU_MUL_EN
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] mcand_n;
  logic [W-1:0]   mplier;
  logic [W-1:0]   mplier_n;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_n;
  logic [SHW-1:0] cnt;
  logic [SHW-1:0] cnt_n;
`endif

  alu_core #(.W(W)) u_core (
    .a  (acc),
    .b  (b),
    .op (op),
    .r  (core_r),
    .f  (core_f)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      flags  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
`endif
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      flags  <= flags_n;
      done   <= done_n;
      err    <= err_n;
`ifdef ALU_MUL_EN
      mcand  <= mcand_n;
      mplier <= mplier_n;
      prod   <= prod_n;
      cnt    <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    flags_n  = flags;
    done_n   = 1'b0;
    err_n    = 1'b0;
`ifdef ALU_MUL_EN
    mcand_n  = mcand;
    mplier_n = mplier;
    prod_n   = prod;
    cnt_n    = cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (load) begin
          acc_n   = b;
          flags_n = '0;
        end else if (start) begin
          if (op == OP_MUL) begin
`ifdef ALU_MUL_EN
            // Operands are frozen here; b may change while iterating.
            state_n  = S_MUL;
            mcand_n  = {{W{1'b0}}, acc};
            mplier_n = b;
            prod_n   = '0;
            cnt_n    = '0;
`else
            err_n    = 1'b1;
`endif
          end else begin
            flags_n = core_f;
            done_n  = 1'b1;
            if (op != OP_CMP) acc_n = core_r;
          end
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        prod_n   = prod + (mplier[0] ? mcand : '0);
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 1'b1;
        if (cnt == SHW'(W-1)) begin
          state_n   = S_IDLE;
          acc_n     = prod_n[W-1:0];
          flags_n.n = prod_n[W-1];
          flags_n.z = (prod_n[W-1:0] == '0);
          flags_n.v = |prod_n[2*W-1:W];
          flags_n.c = |prod_n[2*W-1:W];
          done_n    = 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_accum.sv
// Directed self-checking bench for alu_accum at W=8.
// Covers both ALU_MUL_EN builds.
module tb_alu_accum;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       load;
  logic       start;
  op_e        op;
  logic [7:0] b;
  logic [7:0] acc;
  flags_t     flags;
  logic       busy;
  logic       done;
  logic       err;

  int n_run;
  int n_fail;

  alu_accum #(.W(8)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .load      (load),
    .start     (start),
    .op        (op),
    .b         (b),
    .acc       (acc),
    .flags     (flags),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(logic [7:0] v);
    load = 1'b1;
    b    = v;
    tick();
    load = 1'b0;
  endtask

  // Issue one single-cycle op; afterwards the result edge has passed.
  task automatic do_op(op_e o, logic [7:0] v);
    op    = o;
    b     = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(string tag, logic [7:0] a, op_e o,
                        logic [7:0] v, logic [7:0] r, logic [3:0] f);
    do_load(a);
    do_op(o, v);
    check({tag, "_acc"}, 32'(acc), 32'(r));
    check({tag, "_flg"}, 32'(flags), 32'(f));
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

`ifdef ALU_MUL_EN
  // Wait out a MUL; returns busy-cycle count and done pulses seen early.
  task automatic wait_mul(output int nb, output int nd);
    nb = 0;
    nd = 0;
    while (busy && nb < 20) begin
      if (done) nd++;
      tick();
      nb++;
    end
  endtask
`endif

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    load   = 1'b0;
    start  = 1'b0;
    op     = ALU_ADD;
    b      = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_acc", 32'(acc), 32'h0);
    check("rst_flg", 32'(flags), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    run_op("add_ovf", 8'h7F, ALU_ADD, 8'h01, 8'h80, 4'b1010);
    tick();
    check("add_done_low", 32'(done), 32'h0);

    run_op("sub_brw", 8'h00, ALU_SUB, 8'h01, 8'hFF, 4'b1001);
    do_op(ALU_CMP, 8'hFF);
    check("cmp_acc", 32'(acc), 32'hFF);
    check("cmp_flg", 32'(flags), 32'b0100);

    run_op("ror", 8'h81, ALU_ROR, 8'h03, 8'h30, 4'b0000);
    do_op(ALU_SHL, 8'h04);
    check("shl_acc", 32'(acc), 32'h00);
    check("shl_flg", 32'(flags), 32'b0101);

    run_op("sar", 8'h81, ALU_SAR, 8'h01, 8'hC0, 4'b1001);
    run_op("shr0", 8'h81, ALU_SHR, 8'h00, 8'h81, 4'b1000);
    run_op("shr3", 8'h8C, ALU_SHR, 8'h03, 8'h11, 4'b0001);
    run_op("rol", 8'h81, ALU_ROL, 8'h01, 8'h03, 4'b0000);
    run_op("add_c", 8'hFF, ALU_ADD, 8'h01, 8'h00, 4'b0101);
    run_op("xor", 8'hF0, ALU_XOR, 8'hFF, 8'h0F, 4'b0000);
    run_op("and", 8'hF0, ALU_AND, 8'h3C, 8'h30, 4'b0000);
    run_op("not", 8'h0F, ALU_NOT, 8'h00, 8'hF0, 4'b1000);
    run_op("pass", 8'h12, ALU_PASS, 8'h00, 8'h00, 4'b0100);
    run_op("inc", 8'h7F, ALU_INC, 8'h00, 8'h80, 4'b1010);
    run_op("dec", 8'h00, ALU_DEC, 8'h00, 8'hFF, 4'b1001);
    run_op("sub_v", 8'h80, ALU_SUB, 8'h01, 8'h7F, 4'b0010);

    // Load beats start in the same cycle.
    do_load(8'h55);
    load  = 1'b1;
    start = 1'b1;
    op    = ALU_ADD;
    b     = 8'h22;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check("ld_st_acc", 32'(acc), 32'h22);
    check("ld_st_flg", 32'(flags), 32'h0);
    check("ld_st_done", 32'(done), 32'h0);

`ifdef ALU_MUL_EN
    begin
      int nb;
      int nd;
      do_load(8'h10);
      op    = OP_MUL;
      b     = 8'h10;
      start = 1'b1;
      tick();
      // Retry plus load while busy must be ignored, as must b changes.
      op    = ALU_ADD;
      b     = 8'h55;
      load  = 1'b1;
      tick();
      start = 1'b0;
      load  = 1'b0;
      b     = 8'hAA;
      wait_mul(nb, nd);
      check("mul_busy_len", 32'(nb + 1), 32'd8);
      check("mul_early_done", 32'(nd), 32'd0);
      check("mul_acc", 32'(acc), 32'h00);
      check("mul_flg", 32'(flags), 32'b0111);
      check("mul_done", 32'(done), 32'd1);
      tick();
      check("mul_done_low", 32'(done), 32'd0);
      check("mul_retry_acc", 32'(acc), 32'h00);

      do_load(8'h03);
      op    = OP_MUL;
      b     = 8'h05;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_acc", 32'(acc), 32'h0);
      check("abort_flg", 32'(flags), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      repeat (10) begin
        tick();
        if (done) check("abort_late_done", 32'(done), 32'd0);
      end

      do_load(8'h03);
      op    = OP_MUL;
      b     = 8'h05;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mul(nb, nd);
      check("mul2_busy_len", 32'(nb), 32'd8);
      check("mul2_acc", 32'(acc), 32'h0F);
      check("mul2_flg", 32'(flags), 32'b0000);
      check("mul2_done", 32'(done), 32'd1);
    end
`else
    do_load(8'h5A);
    op    = OP_MUL;
    b     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ill_err", 32'(err), 32'd1);
    check("ill_acc", 32'(acc), 32'h5A);
    check("ill_flg", 32'(flags), 32'h0);
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_done", 32'(done), 32'd0);
    tick();
    check("ill_err_low", 32'(err), 32'd0);
    check("ill_busy2", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
